// File: rtl/mmio_io_subsys.sv
// RAM plus memory-mapped IO page (LED, UART TX with FIFO, UART RX) for a
// single-cycle core. Loads are combinational; all state updates on posedge clk.
module mmio_io_subsys #(
  parameter int          RAM_DEPTH     = 1024,
  parameter logic [31:0] IO_BASE       = 32'h1000_0000,
  parameter int          LED_WIDTH     = 8,
  parameter int          CLK_DIV       = 434,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic [1:0]           mem_ctrl,
  output logic [31:0]          rdata,
  input  logic                 rx,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 tx
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;

  // ---------------- decode ----------------
  logic          io_sel;
  logic [11:0]   off;
  logic [AW-1:0] ram_idx;
  logic          led_we, tx_push_req, st_we, rx_pop;

  assign io_sel      = (addr[31:12] == IO_BASE[31:12]);
  assign off         = addr[11:0];
  assign ram_idx     = addr[AW+1:2];
  assign led_we      = we && io_sel && (off == 12'h000);
  assign tx_push_req = we && io_sel && (off == 12'h004);
  assign st_we       = we && io_sel && (off == 12'h008);
  assign rx_pop      = we && io_sel && (off == 12'h00C);

  // ---------------- state ----------------
  logic [31:0]          mem_q [RAM_DEPTH];
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [7:0]           fifo_q [TX_FIFO_DEPTH];
  logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 tx_empty, tx_full, tx_idle, tx_pop, tx_push;
  tx_st_e               tx_st_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [7:0]           tx_sh_q;
  logic                 tx_q;
  rx_st_e               rx_st_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [7:0]           rx_sh_q, rx_byte_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic                 rx_valid_q, overrun_q, frame_err_q;

  // ---------------- RAM ----------------
  logic [3:0]  be;
  logic [31:0] wlane, ram_word;

  // Byte-enable and lane replication for stores; misaligned accesses are forced aligned
  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    case (mem_ctrl)
      2'b00: begin be = 4'b0001 << addr[1:0]; wlane = {4{wdata[7:0]}};  end
      2'b01: begin be = addr[1] ? 4'b1100 : 4'b0011; wlane = {2{wdata[15:0]}}; end
      default: ;
    endcase
  end

  // RAM store with byte lanes; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we && !io_sel)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[ram_idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  assign ram_word = mem_q[ram_idx];

  // Combinational load mux: IO registers or zero-extended RAM byte/half/word
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      case (off)
        12'h000: rdata = 32'(led_q);
        12'h008: rdata = {27'b0, frame_err_q, overrun_q, rx_valid_q, tx_idle, tx_full};
        12'h00C: rdata = {23'b0, rx_valid_q, rx_byte_q};
        default: rdata = '0;
      endcase
    end else begin
      case (mem_ctrl)
        2'b00:   rdata = {24'b0, ram_word[{addr[1:0], 3'b000} +: 8]};
        2'b01:   rdata = {16'b0, addr[1] ? ram_word[31:16] : ram_word[15:0]};
        default: rdata = ram_word;
      endcase
    end
  end

  // ---------------- LED ----------------
  // LED register next-state
  always_comb led_d = led_we ? wdata[LED_WIDTH-1:0] : led_q;

  // LED register
  always_ff @(posedge clk) begin
    if (reset) led_q <= '0;
    else       led_q <= led_d;
  end
  assign led_out = led_q;

  // ---------------- TX FIFO ----------------
  assign tx_empty = (wr_ptr_q == rd_ptr_q);
  assign tx_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign tx_idle  = tx_empty && (tx_st_q == TX_IDLE);
  // Pop only when a byte exists, so a push into an empty FIFO always sticks
  assign tx_pop   = !tx_empty && ((tx_st_q == TX_IDLE) || (tx_st_q == TX_STOP && tx_cnt_q == BIT_END));
  // Pop frees a slot first, so a push to a full FIFO succeeds when a pop coincides
  assign tx_push  = tx_push_req && (!tx_full || tx_pop);

  // FIFO pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(tx_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(tx_pop);
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) fifo_q[wr_ptr_q[PW-1:0]] <= wdata[7:0];
  end

  // ---------------- TX FSM ----------------
  // 8N1 transmitter, LSB first; STOP chains straight into START when more data waits
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q  <= TX_IDLE;
      tx_q     <= 1'b1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      case (tx_st_q)
        TX_IDLE: if (tx_pop) begin
          tx_sh_q  <= fifo_q[rd_ptr_q[PW-1:0]];
          tx_st_q  <= TX_START;
          tx_q     <= 1'b0;
          tx_cnt_q <= '0;
        end
        TX_START: if (tx_cnt_q == BIT_END) begin
          tx_st_q  <= TX_DATA;
          tx_q     <= tx_sh_q[0];
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        TX_DATA: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_q <= TX_STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_sh_q  <= tx_sh_q >> 1;
            tx_q     <= tx_sh_q[1];
          end
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        TX_STOP: if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_sh_q <= fifo_q[rd_ptr_q[PW-1:0]];
            tx_st_q <= TX_START;
            tx_q    <= 1'b0;
          end else tx_st_q <= TX_IDLE;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end
  assign tx = tx_q;

  // ---------------- RX ----------------
  // Synchroniser, receiver FSM and RX status flags; frame completion overrides a same-cycle pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_pop)               rx_valid_q  <= 1'b0;
      if (st_we && wdata[3])    overrun_q   <= 1'b0;
      if (st_we && wdata[4])    frame_err_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          else                  rx_bit_q <= rx_bit_q + 3'd1;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_STOP: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q <= '0;
          rx_st_q  <= RX_IDLE;
          if (rx_s2_q) begin
            rx_byte_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !rx_pop) overrun_q <= 1'b1;
          end else frame_err_q <= 1'b1;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_io_subsys.sv
// Directed bench for mmio_io_subsys: RAM lanes, LED, UART TX/RX, reset abort.
module tb_mmio_io_subsys;
  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 8;
  localparam int          RAMD    = 64;
  localparam logic [31:0] IOB     = 32'h1000_0000;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset, we, rx;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  mem_ctrl;
  logic [7:0]  led_out;
  logic        tx;

  mmio_io_subsys #(.RAM_DEPTH(RAMD), .IO_BASE(IOB), .LED_WIDTH(8),
                   .CLK_DIV(CLK_DIV), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .mem_ctrl(mem_ctrl), .rdata(rdata), .rx(rx), .led_out(led_out), .tx(tx));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] sb_q[$];
  logic [8:0]  exp_tx_q[$], got_q[$];
  int          start_q[$];
  bit          mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle store; consecutive calls keep we high on consecutive edges
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
    @(negedge clk);
    addr = a; wdata = d; mem_ctrl = c; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [1:0] c,
                        input logic [31:0] exp);
    sb_q.push_back(exp);
    @(negedge clk);
    addr = a; mem_ctrl = c; we = 1'b0;
    #1;
    chk(tag, rdata, sb_q.pop_front());
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (CLK_DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx = b[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk); rx = stop;
    repeat (CLK_DIV - 1) @(negedge clk);
    @(negedge clk); rx = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) @(negedge clk);
    chk("tx_frame_count", got_q.size(), n);
  endtask

  task automatic cmp_frames(input string tag);
    while (got_q.size() > 0 && exp_tx_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_tx_q.pop_front());
  endtask

  // UART line monitor: samples mid-bit, records {stop, data} per frame
  initial begin : tx_mon
    logic [8:0] fr;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          fr[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        fr[8] = tx;
        got_q.push_back(fr);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; rx = 1'b1; addr = '0; wdata = '0; mem_ctrl = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_tx", 32'(tx), 32'h1);
    rd_chk("rst_status", IOB + 32'h8, 2'b10, 32'h2);

    // RAM lanes
    wr(32'h10, 32'hDEAD_BEEF, 2'b10);
    wr(32'h11, 32'h0000_0055, 2'b00);
    rd_chk("ram_word", 32'h10, 2'b10, 32'hDEAD_55EF);
    rd_chk("ram_byte", 32'h13, 2'b00, 32'h0000_00DE);
    rd_chk("ram_half", 32'h12, 2'b01, 32'h0000_DEAD);
    rd_chk("ram_half_mis", 32'h11, 2'b01, 32'h0000_55EF);
    wr(RAMD * 4 + 32'h20, 32'h1234_5678, 2'b10);
    rd_chk("ram_wrap", 32'h20, 2'b10, 32'h1234_5678);
    wr(32'h23, 32'h0000_ABCD, 2'b01);
    rd_chk("ram_half_wr_mis", 32'h20, 2'b10, 32'hABCD_5678);

    // LED and unmapped IO
    wr(IOB, 32'h1A5, 2'b10);
    chk("led_set", 32'(led_out), 32'hA5);
    rd_chk("led_rd", IOB, 2'b10, 32'hA5);
    rd_chk("io_unmapped", IOB + 32'h10, 2'b10, 32'h0);
    wr(IOB + 32'h40, 32'hFFFF_FFFF, 2'b10);
    chk("led_unmapped_wr", 32'(led_out), 32'hA5);
    wr(IOB, 32'h0, 2'b10);
    chk("led_clr", 32'(led_out), 32'h0);

    // TX back-to-back frames
    exp_tx_q.push_back({1'b1, 8'h41});
    exp_tx_q.push_back({1'b1, 8'h42});
    wr(IOB + 32'h4, 32'h41, 2'b10);
    wr(IOB + 32'h4, 32'h42, 2'b10);
    rd_chk("status_busy", IOB + 32'h8, 2'b10, 32'h0);
    rd_chk("txdata_rd", IOB + 32'h4, 2'b10, 32'h0);
    wait_frames(2, 4 * FRAME);
    if (start_q.size() >= 2) chk("tx_gap", start_q[1] - start_q[0], FRAME);
    cmp_frames("tx_frame");
    repeat (4) @(negedge clk);
    rd_chk("status_done", IOB + 32'h8, 2'b10, 32'h2);
    start_q.delete();

    // FIFO overflow: DEPTH+2 pushes, DEPTH+1 frames
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i <= DEPTH) exp_tx_q.push_back({1'b1, 8'(8'h60 + i)});
      wr(IOB + 32'h4, 32'(8'h60 + i), 2'b10);
    end
    rd_chk("status_full", IOB + 32'h8, 2'b10, 32'h1);
    wait_frames(DEPTH + 1, (DEPTH + 3) * FRAME);
    repeat (2 * FRAME) @(negedge clk);
    chk("tx_no_extra", got_q.size(), DEPTH + 1);
    cmp_frames("tx_fifo_frame");
    rd_chk("status_drained", IOB + 32'h8, 2'b10, 32'h2);

    // RX: valid, overrun, clear, pop, frame error, glitch
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("rx_data1", IOB + 32'hC, 2'b10, 32'h13C);
    rd_chk("rx_status1", IOB + 32'h8, 2'b10, 32'h6);
    send_rx(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("rx_overrun", IOB + 32'h8, 2'b10, 32'hE);
    rd_chk("rx_data2", IOB + 32'hC, 2'b10, 32'h15A);
    wr(IOB + 32'h8, 32'h8, 2'b10);
    rd_chk("ovr_clr", IOB + 32'h8, 2'b10, 32'h6);
    wr(IOB + 32'hC, 32'h0, 2'b10);
    rd_chk("rx_pop", IOB + 32'h8, 2'b10, 32'h2);
    send_rx(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    rd_chk("frame_err", IOB + 32'h8, 2'b10, 32'h12);
    rd_chk("frame_err_data", IOB + 32'hC, 2'b10, 32'h05A);
    wr(IOB + 32'h8, 32'h10, 2'b10);
    rd_chk("ferr_clr", IOB + 32'h8, 2'b10, 32'h2);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    rd_chk("rx_glitch", IOB + 32'h8, 2'b10, 32'h2);

    // Reset mid TX frame (data bit 2 of 0xF0 is low)
    mon_en = 1'b0;
    wr(IOB, 32'h3C, 2'b10);
    wr(IOB + 32'h4, 32'hF0, 2'b10);
    repeat (15) @(negedge clk);
    chk("tx_low_mid", 32'(tx), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(tx), 32'h1);
    chk("rst_mid_led", 32'(led_out), 32'h0);
    @(negedge clk); reset = 1'b0;
    rd_chk("rst_mid_status", IOB + 32'h8, 2'b10, 32'h2);
    repeat (FRAME) @(negedge clk);
    chk("tx_stays_idle", 32'(tx), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
